drum_pad_trigger: RTL and testbench

Conditions the raw piezo-comparator trigger lines from the drum pads into clean, stretched hit levels for the CPU poll port. Each channel synchronises, debounces and stretches its input, then waits for release before re-arming. `hit_out` drives the 8-bit poll PIO `in_port` directly, so a masked, level-sensitive interrupt sees each strike exactly once for `HOLD_CYCLES`. A one-cycle `hit_strobe` per channel is provided for the audio trigger path.

---
 rtl/drum_pad_trigger.sv | 81 ++++++++
 tb/tb_drum_pad_trigger.sv | 98 +++++++++
 2 files changed

// File: rtl/drum_pad_trigger.sv
// drum_pad_trigger: per-channel synchronise, debounce, stretch and release re-arm of piezo pad triggers
module drum_pad_trigger #(
  parameter int CHANNELS = 8,
  parameter int DEBOUNCE_CYCLES = 500,
  parameter int HOLD_CYCLES = 50000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] pad_raw,
  input  logic [CHANNELS-1:0] enable,
  output logic [CHANNELS-1:0] hit_out,
  output logic [CHANNELS-1:0] hit_strobe
);
  localparam int MAX_CYCLES = DEBOUNCE_CYCLES > HOLD_CYCLES ? DEBOUNCE_CYCLES : HOLD_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] DEB_N = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] HOLD_N = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] ONE = CW'(1);
  typedef enum logic [1:0] {IDLE, ARM, HOLD, REARM} state_t;
  logic [CHANNELS-1:0] sync_q, pad_s_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      pad_s_q <= '0;
    end else begin
      sync_q <= pad_raw;
      pad_s_q <= sync_q;
    end
  end
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic hit_q, hit_d, strobe_q, strobe_d, pad, deb_done;
    always_comb begin
      pad = pad_s_q[c];
      cnt_inc = cnt_q + ONE;
      deb_done = cnt_inc == DEB_N;
      state_d = state_q;
      cnt_d = cnt_inc;
      case (state_q)
        IDLE: begin
          state_d = !pad ? IDLE : DEB_N == ONE ? HOLD : ARM;
          cnt_d = pad ? ONE : '0;
        end
        ARM: begin
          state_d = !pad ? IDLE : deb_done ? HOLD : ARM;
          cnt_d = !pad ? '0 : deb_done ? ONE : cnt_inc;
        end
        HOLD: begin
          state_d = cnt_q == HOLD_N ? REARM : HOLD;
          cnt_d = cnt_q == HOLD_N ? '0 : cnt_inc;
        end
        REARM: begin
          state_d = !pad && deb_done ? IDLE : REARM;
          cnt_d = pad || deb_done ? '0 : cnt_inc;
        end
      endcase
      if (!enable[c]) begin
        state_d = IDLE;
        cnt_d = '0;
      end
      hit_d = state_d == HOLD;
      strobe_d = hit_d && state_q != HOLD;
    end
    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= IDLE;
        cnt_q <= '0;
        hit_q <= 1'b0;
        strobe_q <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q <= cnt_d;
        hit_q <= hit_d;
        strobe_q <= strobe_d;
      end
    end
    assign hit_out[c] = hit_q;
    assign hit_strobe[c] = strobe_q;
  end
endmodule

// File: tb/tb_drum_pad_trigger.sv
// tb_drum_pad_trigger: directed scoreboard bench for drum_pad_trigger with DEBOUNCE_CYCLES=4, HOLD_CYCLES=8
module tb_drum_pad_trigger;
  logic clk, rst;
  logic [7:0] raw, en, hit_out, hit_strobe;
  int checks = 0;
  int errors = 0;
  typedef struct {
    string tag;
    logic [7:0] hit;
    logic [7:0] stb;
  } exp_t;
  exp_t q[$];
  drum_pad_trigger #(.CHANNELS(8), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(8)) dut (
    .clk(clk),
    .reset(rst),
    .pad_raw(raw),
    .enable(en),
    .hit_out(hit_out),
    .hit_strobe(hit_strobe)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [7:0] win(input int k, input int lo, input int hi, input logic [7:0] v);
    return (k >= lo && k <= hi) ? v : 8'h00;
  endfunction
  task automatic cyc(input logic [7:0] eh, input logic [7:0] es, input string tag);
    exp_t e;
    e.tag = tag;
    e.hit = eh;
    e.stb = es;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    checks++;
    assert (hit_out === e.hit) else begin
      errors++;
      $error("FAIL %s hit_out got=%h exp=%h", e.tag, hit_out, e.hit);
    end
    checks++;
    assert (hit_strobe === e.stb) else begin
      errors++;
      $error("FAIL %s hit_strobe got=%h exp=%h", e.tag, hit_strobe, e.stb);
    end
  endtask
  task automatic quiet(input int n, input string tag);
    raw = 8'h00;
    for (int k = 0; k < n; k++) cyc(8'h00, 8'h00, tag);
  endtask
  initial begin
    rst = 1'b1;
    raw = 8'hFF;
    en = 8'hFF;
    for (int k = 0; k < 3; k++) cyc(8'h00, 8'h00, "reset");
    rst = 1'b0;
    for (int k = 0; k < 16; k++) cyc(win(k, 5, 12, 8'hFF), win(k, 5, 5, 8'hFF), "post_reset_all");
    quiet(10, "all_release");
    raw = 8'h01;
    for (int k = 0; k < 40; k++) cyc(win(k, 5, 12, 8'h01), win(k, 5, 5, 8'h01), "ch0_press_held");
    raw = 8'h00;
    for (int k = 0; k < 3; k++) cyc(8'h00, 8'h00, "ch0_short_release");
    raw = 8'h01;
    for (int k = 0; k < 10; k++) cyc(8'h00, 8'h00, "ch0_no_rearm");
    quiet(6, "ch0_full_release");
    raw = 8'h01;
    for (int k = 0; k < 20; k++) cyc(win(k, 5, 12, 8'h01), win(k, 5, 5, 8'h01), "ch0_second_hit");
    quiet(10, "ch0_release");
    raw = 8'h08;
    for (int k = 0; k < 3; k++) cyc(8'h00, 8'h00, "ch3_glitch");
    quiet(10, "ch3_glitch_after");
    for (int k = 0; k < 20; k++) begin
      raw = k < 4 ? 8'h08 : 8'h00;
      cyc(win(k, 5, 12, 8'h08), win(k, 5, 5, 8'h08), "ch3_min_press");
    end
    quiet(4, "ch3_idle");
    for (int k = 0; k < 25; k++) begin
      raw = k >= 3 ? 8'h46 : 8'h42;
      cyc(win(k, 5, 12, 8'h42) | win(k, 8, 15, 8'h04), win(k, 5, 5, 8'h42) | win(k, 8, 8, 8'h04), "ch1_2_6_simul");
    end
    quiet(10, "simul_release");
    raw = 8'h20;
    for (int k = 0; k < 12; k++) begin
      en = k >= 8 ? 8'hDF : 8'hFF;
      cyc(win(k, 5, 7, 8'h20), win(k, 5, 5, 8'h20), "ch5_disable_hold");
    end
    en = 8'hFF;
    quiet(10, "ch5_reenable");
    raw = 8'h80;
    for (int k = 0; k < 9; k++) cyc(win(k, 5, 12, 8'h80), win(k, 5, 5, 8'h80), "ch7_hold");
    rst = 1'b1;
    cyc(8'h00, 8'h00, "ch7_reset_mid_hold");
    rst = 1'b0;
    for (int k = 0; k < 14; k++) cyc(win(k, 5, 12, 8'h80), win(k, 5, 5, 8'h80), "ch7_held_after_reset");
    quiet(10, "final_release");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
